// File: rtl/asic_iopoc_seq.sv
// asic_iopoc_seq: staggered padring POC sequencer; ports clk, rst, en, vddio_ok[N] in; poc[N], ready, fault, fault_seg[N] out
module asic_iopoc_seq #(
  parameter int N       = 4,
  parameter int STABLE  = 16,
  parameter int STAGGER = 4,
  parameter int CW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] vddio_ok,
  output logic [N-1:0] poc,
  output logic         ready,
  output logic         fault,
  output logic [N-1:0] fault_seg
);
  localparam int IW = $clog2(N + 1);
  typedef enum logic [2:0] {ST_OFF, ST_WAIT, ST_REL, ST_ON, ST_FAULT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  poc_q, poc_d, fault_seg_q, fault_seg_d, s1_q, ok_s_q;
  logic          ready_q, ready_d, fault_q, fault_d;
  logic          all_ok;
  assign all_ok    = &ok_s_q;
  assign poc       = poc_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign fault_seg = fault_seg_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    poc_d       = poc_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    fault_seg_d = fault_seg_q;
    case (state_q)
      ST_OFF: begin
        poc_d   = '1;
        ready_d = 1'b0;
        if (en) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_FAULT: if (!en) begin
        state_d     = ST_OFF;
        fault_d     = 1'b0;
        fault_seg_d = '0;
      end
      default: if (!en) begin
        state_d = ST_OFF;
        poc_d   = '1;
        ready_d = 1'b0;
      end else if (!all_ok) begin
        // a dip while waiting only restarts the stability window
        if (state_q == ST_WAIT) cnt_d = '0;
        else begin
          state_d     = ST_FAULT;
          poc_d       = '1;
          ready_d     = 1'b0;
          fault_d     = 1'b1;
          fault_seg_d = ~ok_s_q;
        end
      end else if (state_q == ST_WAIT) begin
        if (cnt_q == CW'(STABLE - 1)) begin
          poc_d   = {N{1'b1}} << 1;
          idx_d   = IW'(1);
          cnt_d   = '0;
          state_d = (N == 1) ? ST_ON : ST_REL;
          ready_d = (N == 1);
        end else cnt_d = cnt_q + CW'(1);
      end else if (state_q == ST_REL) begin
        if (cnt_q == CW'(STAGGER - 1)) begin
          poc_d = poc_q & ~(N'(1) << idx_q);
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
          if (idx_q == IW'(N - 1)) begin
            state_d = ST_ON;
            ready_d = 1'b1;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      poc_q       <= '1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_seg_q <= '0;
      s1_q        <= '0;
      ok_s_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      poc_q       <= poc_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      fault_seg_q <= fault_seg_d;
      s1_q        <= vddio_ok;
      ok_s_q      <= s1_q;
    end
  end
endmodule

// File: doc/asic_iopoc_seq.md
Name: asic_iopoc_seq

Overview:
- Parametrised power-on-control (POC) sequencer for the padring.
- Generalises the passive supply and ground cells to N padring segments, each with its own poc line.
- Waits for every segment's IO-supply-good flag to be stable, then releases the segment poc lines one at a time with a programmable stagger to limit inrush.
- Re-clamps all IO immediately on any supply loss and records which segments faulted.

Parameters:
N, 4, number of padring segments (poc lines / supply-good inputs), N >= 1
STABLE, 16, consecutive good sampled cycles required before the first release, 1..2^CW
STAGGER, 4, cycles between successive segment releases, 1..2^CW
CW, 8, counter width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
en  input  1  sequencer enable; low requests orderly shutdown (all poc asserted)
vddio_ok  input  N  per-segment IO-supply-good, asynchronous
poc  output  N  per-segment power-on-control; 1 = IO held in safe state
ready  output  1  all segments released, state ON
fault  output  1  sticky supply-loss flag
fault_seg  output  N  sync'd vddio_ok inverted, captured at fault entry

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst.
- Reset values: state OFF, poc = all 1, ready = 0, fault = 0, fault_seg = 0, counters = 0, synchronizer flops = 0.
- vddio_ok passes through a 2-flop synchronizer per bit to give ok_s, with 2 edges of latency. all_ok = &ok_s.
- State OFF:
  - poc = all 1.
  - en=1 -> WAIT; cnt = 0.
- State WAIT:
  - en=0 -> OFF.
  - else all_ok=0 -> cnt = 0, stay.
  - else cnt == STABLE-1 -> RELEASE; clear poc[0] on this edge; idx = 1; cnt = 0.
  - else cnt++.
- State RELEASE:
  - Each edge with all_ok=1 increments cnt.
  - When cnt == STAGGER-1: clear poc[idx], idx++, cnt = 0.
  - poc[k] clears exactly STAGGER edges after poc[k-1].
  - On the edge that clears poc[N-1]: state -> ON and ready = 1 on the same edge.
  - N=1: WAIT goes directly to ON; poc[0] and ready change on the same edge.
- State ON:
  - poc = 0, ready = 1.
- Fault (RELEASE or ON, en=1, all_ok=0), on the next edge:
  - poc = all 1, ready = 0, fault = 1.
  - fault_seg = ~ok_s.
  - state -> FAULT.
- State FAULT:
  - poc = all 1; fault and fault_seg hold.
  - Stays in FAULT even if supplies recover.
  - en=0 -> OFF; fault and fault_seg clear on that edge.
- en=0 in WAIT, RELEASE or ON -> OFF on the next edge:
  - poc = all 1, ready = 0, no fault recorded.
- Priority: rst > en=0 > supply fault > counting.
- Supply dips during WAIT only restart the stability count; no fault is recorded.
- rst mid-sequence returns to the reset values on that edge, regardless of state.
- poc bits only ever go 1->0 in ascending index order. All 0->1 transitions occur together.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Nominal sequence (N=4, STABLE=16, STAGGER=4):
   - Stimulus: after rst release, en=1 and vddio_ok=4'hF before edge 0.
   - Required: state WAIT at E0.
   - poc = 4'b1110 at E17, 4'b1100 at E21, 4'b1000 at E25.
   - poc = 4'b0000 with ready=1 at E29; fault = 0 throughout.
2. Stability restart:
   - Stimulus: as in 1, but vddio_ok[2] pulses low for one cycle (sampled at E10).
   - Required: cnt restarts; poc[0] clears at E10+2+16 = E28 instead of E17; no fault.
3. Fault in ON:
   - Stimulus: from ready=1, drop vddio_ok[1] at edge T.
   - Required: at T+3, poc = 4'hF, ready=0, fault=1, fault_seg = 4'b0010.
   - Restore vddio_ok: state stays FAULT.
   - en=0 -> OFF with fault=0 and fault_seg=0 on the next edge.
4. Shutdown mid-RELEASE:
   - Stimulus: en=0 while poc = 4'b1100.
   - Required: next edge poc = 4'hF, ready=0, fault=0.
   - en=1 again -> full sequence restarts from WAIT.
5. Simultaneous events:
   - Stimulus: en=0 and vddio_ok low in the same cycle during ON.
   - Required: OFF, fault stays 0.
   - Stimulus: rst asserted during FAULT.
   - Required: all reset values on that edge.
6. Edge parameters:
   - Config N=1, STABLE=1, STAGGER=1.
   - Required: poc[0] clears and ready asserts on the first edge after ok_s goes high.
   - Config N=3, STAGGER=1.
   - Required: poc releases on 3 consecutive edges.
